// File: rtl/urd_timer_pkg.sv
// urd_timer_pkg: shared types and constants for the urd_timer microsecond
// timebase and its compare channels.
//   cmp_mode_e          : channel mode latched when a channel is armed
//   URD_CLK_DIV_DEFAULT : default clock cycles per tick
//   URD_MAX_CH          : largest supported number of compare channels
package urd_timer_pkg;

  typedef enum logic {
    CMP_ONESHOT  = 1'b0,
    CMP_PERIODIC = 1'b1
  } cmp_mode_e;

  localparam int unsigned URD_CLK_DIV_DEFAULT = 48;
  localparam int unsigned URD_MAX_CH          = 8;

endpackage

// File: rtl/urd_timer_ch.sv
// urd_timer_ch: one compare channel of urd_timer. Holds an absolute target,
// a reload period, the armed bit and a sticky interrupt flag.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_tick       : counter advances this cycle
//   i_cnt        : current counter value (used to compute a new target)
//   i_cnt_nxt    : counter value after this tick (compared to the target)
//   i_we         : arm (i_val != 0) or cancel (i_val == 0) strobe
//   i_val        : relative delay in ticks
//   i_per        : 1 = periodic, 0 = one-shot, sampled at arm
//   i_clr        : write-1-to-clear for the flag
//   o_irq        : sticky match flag
//   o_armed      : channel armed
module urd_timer_ch
  import urd_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_cnt_nxt,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_per,
  input  logic             i_clr,
  output logic             o_irq,
  output logic             o_armed
);

  logic [CNT_W-1:0] r_tgt;
  logic [CNT_W-1:0] r_per;
  cmp_mode_e        r_mode;
  logic             r_armed;
  logic             r_irq;

  logic w_arm;
  logic w_cancel;
  logic w_hit;

  // A write to the channel in the same cycle as a match suppresses the match.
  always_comb begin
    w_arm    = i_we && (i_val != '0);
    w_cancel = i_we && (i_val == '0);
    w_hit    = i_tick && r_armed && !i_we && (i_cnt_nxt == r_tgt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt   <= '0;
      r_per   <= '0;
      r_mode  <= CMP_ONESHOT;
      r_armed <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_arm) begin
        r_tgt   <= i_cnt + i_val;
        r_mode  <= i_per ? CMP_PERIODIC : CMP_ONESHOT;
        r_per   <= i_per ? i_val : '0;
        r_armed <= 1'b1;
      end else if (w_cancel) begin
        r_armed <= 1'b0;
      end else if (w_hit) begin
        if (r_mode == CMP_PERIODIC) begin
          r_tgt <= r_tgt + r_per;
        end else begin
          r_armed <= 1'b0;
        end
      end

      // Setting the flag takes precedence over clearing it.
      if (w_hit) begin
        r_irq <= 1'b1;
      end else if (i_clr) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign o_irq   = r_irq;
  assign o_armed = r_armed;

endmodule

// File: rtl/urd_timer.sv
// urd_timer: microsecond timebase. An exact prescaler divides clk_i into a
// tick that advances a loadable, pausable CNT_W-bit counter; N_CH compare
// channels raise sticky flags on one-shot or periodic matches.
// Optional build macro URD_TIMER_CAPTURE_EN adds an input-capture unit.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   en_i                   : count enable (prescaler and counter hold when low)
//   ld_i, ld_val_i         : counter load strobe and value
//   t_out, tick_o          : counter value, pulse when t_out has just advanced
//   cmp_we_i               : per-channel arm/cancel strobes
//   cmp_val_i, cmp_per_i   : shared delay and periodic mode
//   irq_clr_i              : write-1-to-clear for irq_o (bit 0 also cap_flag_o)
//   irq_o, armed_o         : per-channel flags and armed status
//   cap_i                  : asynchronous capture pin (capture build only)
//   cap_val_o, cap_flag_o  : captured counter value and flag (capture build only)
module urd_timer
  import urd_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = URD_CLK_DIV_DEFAULT,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned N_CH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic [CNT_W-1:0] t_out,
  output logic             tick_o,
  input  logic [N_CH-1:0]  cmp_we_i,
  input  logic [CNT_W-1:0] cmp_val_i,
  input  logic             cmp_per_i,
  input  logic [N_CH-1:0]  irq_clr_i,
  output logic [N_CH-1:0]  irq_o,
  output logic [N_CH-1:0]  armed_o
`ifdef URD_TIMER_CAPTURE_EN
  ,
  input  logic             cap_i,
  output logic [CNT_W-1:0] cap_val_o,
  output logic             cap_flag_o
`endif
);

  localparam int unsigned       PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Load overrides the tick: a load cycle never advances or matches.
  always_comb begin
    w_tick    = en_i && !ld_i && (r_pre == PRE_LAST);
    w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (ld_i) begin
        r_cnt <= ld_val_i;
        r_pre <= '0;
      end else if (en_i) begin
        if (r_pre == PRE_LAST) begin
          r_pre <= '0;
          r_cnt <= w_cnt_nxt;
        end else begin
          r_pre <= r_pre + PRE_W'(1);
        end
      end
    end
  end

  assign t_out  = r_cnt;
  assign tick_o = r_tick;

  // Channels see the pre-load, pre-increment count for arming.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    urd_timer_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_tick   (w_tick),
      .i_cnt    (r_cnt),
      .i_cnt_nxt(w_cnt_nxt),
      .i_we     (cmp_we_i[k]),
      .i_val    (cmp_val_i),
      .i_per    (cmp_per_i),
      .i_clr    (irq_clr_i[k]),
      .o_irq    (irq_o[k]),
      .o_armed  (armed_o[k])
    );
  end

`ifdef URD_TIMER_CAPTURE_EN
  logic             r_cap_meta;
  logic             r_cap_sync;
  logic             r_cap_prev;
  logic [CNT_W-1:0] r_cap_val;
  logic             r_cap_flag;
  logic             w_cap_edge;

  always_comb begin
    w_cap_edge = r_cap_sync && !r_cap_prev;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cap_meta <= 1'b0;
      r_cap_sync <= 1'b0;
      r_cap_prev <= 1'b0;
      r_cap_val  <= '0;
      r_cap_flag <= 1'b0;
    end else begin
      r_cap_meta <= cap_i;
      r_cap_sync <= r_cap_meta;
      r_cap_prev <= r_cap_sync;
      if (w_cap_edge) begin
        r_cap_val  <= r_cnt;
        r_cap_flag <= 1'b1;
      end else if (irq_clr_i[0]) begin
        r_cap_flag <= 1'b0;
      end
    end
  end

  assign cap_val_o  = r_cap_val;
  assign cap_flag_o = r_cap_flag;
`endif

endmodule

// File: tb/tb_urd_timer.sv
// tb_urd_timer: self-checking bench for urd_timer (CLK_DIV=4, CNT_W=8, N_CH=2).
// Directed scenarios plus randomized traffic against a cycle-level reference
// model written from the block's behavioural rules.
module tb_urd_timer;

  localparam int DIV = 4;
  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int MOD = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] ldv = '0;
  logic [1:0]   we  = '0;
  logic [W-1:0] cv  = '0;
  logic         per = 1'b0;
  logic [1:0]   clr = '0;
  logic [W-1:0] t_out;
  logic         tick_o;
  logic [1:0]   irq_o;
  logic [1:0]   armed_o;
`ifdef URD_TIMER_CAPTURE_EN
  logic         cap = 1'b0;
  logic [W-1:0] cap_val_o;
  logic         cap_flag_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt = 0;
  int m_pre = 0;
  bit m_tick = 0;
  int m_tgt[NCH];
  int m_per[NCH];
  bit m_arm[NCH];
  bit m_irq[NCH];

  urd_timer #(
    .CLK_DIV(DIV),
    .CNT_W  (W),
    .N_CH   (NCH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .ld_i     (ld),
    .ld_val_i (ldv),
    .t_out    (t_out),
    .tick_o   (tick_o),
    .cmp_we_i (we),
    .cmp_val_i(cv),
    .cmp_per_i(per),
    .irq_clr_i(clr),
    .irq_o    (irq_o),
    .armed_o  (armed_o)
`ifdef URD_TIMER_CAPTURE_EN
    ,
    .cap_i     (cap),
    .cap_val_o (cap_val_o),
    .cap_flag_o(cap_flag_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the same edge. Strobes are dropped after the edge.
  task automatic step();
    bit tk;
    bit hit;
    int nxt;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_tick = 0;
      for (int k = 0; k < NCH; k++) begin
        m_tgt[k] = 0; m_per[k] = 0; m_arm[k] = 0; m_irq[k] = 0;
      end
    end else begin
      tk  = en && !ld && (m_pre == DIV - 1);
      nxt = (m_cnt + 1) % MOD;
      for (int k = 0; k < NCH; k++) begin
        hit = 0;
        if (we[k]) begin
          if (cv != 0) begin
            m_tgt[k] = (m_cnt + int'(cv)) % MOD;
            m_per[k] = per ? int'(cv) : 0;
            m_arm[k] = 1;
          end else begin
            m_arm[k] = 0;
          end
        end else if (tk && m_arm[k] && nxt == m_tgt[k]) begin
          hit = 1;
          if (m_per[k] != 0) m_tgt[k] = (m_tgt[k] + m_per[k]) % MOD;
          else m_arm[k] = 0;
        end
        if (hit) m_irq[k] = 1;
        else if (clr[k]) m_irq[k] = 0;
      end
      if (ld) begin
        m_cnt = int'(ldv); m_pre = 0;
      end else if (en) begin
        if (m_pre == DIV - 1) begin m_pre = 0; m_cnt = nxt; end
        else m_pre = m_pre + 1;
      end
      m_tick = tk;
    end
    @(posedge clk);
    #1;
    ld = 1'b0; we = '0; clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ld = 1'b1; ldv = 8'hA5; we = 2'b11; cv = 8'd3;
    step();
    rst = 1'b1; en = 1'b1;
    step(); step();
    checks++; if (t_out !== 8'd0) begin errors++; $display("FAIL reset_t_out: actual=%0d required=0", t_out); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: actual=%b required=0", tick_o); end
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL reset_irq: actual=%b required=00", irq_o); end
    checks++; if (armed_o !== 2'b00) begin errors++; $display("FAIL reset_armed: actual=%b required=00", armed_o); end
`ifdef URD_TIMER_CAPTURE_EN
    checks++; if (cap_flag_o !== 1'b0 || cap_val_o !== 8'd0) begin errors++; $display("FAIL reset_cap: actual=%b/%0d required=0/0", cap_flag_o, cap_val_o); end
`endif
  endtask

  task automatic test_tick_period();
    int nticks;
    int bad;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    nticks = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick_o === 1'b1) nticks++;
      if (tick_o !== ((i % DIV) == 0)) bad++;
    end
    checks++; if (t_out !== 8'd10) begin errors++; $display("FAIL tick_count_value: actual=%0d required=10", t_out); end
    checks++; if (nticks !== 10) begin errors++; $display("FAIL tick_pulses: actual=%0d required=10", nticks); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tick_spacing: misplaced=%0d required=0", bad); end
  endtask

  task automatic test_oneshot();
    int n;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    n = 0; while (m_cnt != 5 && n < 100) begin step(); n++; end
    we = 2'b01; cv = 8'd3; per = 1'b0;
    step();
    checks++; if (armed_o[0] !== 1'b1) begin errors++; $display("FAIL oneshot_armed: actual=%b required=1", armed_o[0]); end
    n = 0; while (irq_o[0] !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL oneshot_timeout: actual=%b required=1", irq_o[0]); end
    checks++; if (t_out !== 8'd8) begin errors++; $display("FAIL oneshot_time: actual=%0d required=8", t_out); end
    checks++; if (armed_o[0] !== 1'b0) begin errors++; $display("FAIL oneshot_disarm: actual=%b required=0", armed_o[0]); end
    clr = 2'b01; step();
    checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL oneshot_clear: actual=%b required=0", irq_o[0]); end
    for (int i = 0; i < 20; i++) step();
    checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL oneshot_stays_clear: actual=%b required=0", irq_o[0]); end
  endtask

  task automatic test_periodic_wrap();
    int n;
    int expv[3];
    expv[0] = 254; expv[1] = 2; expv[2] = 6;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    ld = 1'b1; ldv = 8'd250; step();
    checks++; if (t_out !== 8'd250) begin errors++; $display("FAIL periodic_load: actual=%0d required=250", t_out); end
    we = 2'b10; cv = 8'd4; per = 1'b1; step();
    for (int e = 0; e < 3; e++) begin
      n = 0; while (irq_o[1] !== 1'b1 && n < 40) begin step(); n++; end
      checks++; if (irq_o[1] !== 1'b1 || t_out !== W'(expv[e])) begin
        errors++; $display("FAIL periodic_hit%0d: actual irq=%b t=%0d required irq=1 t=%0d", e, irq_o[1], t_out, expv[e]);
      end
      if (e < 2) begin
        clr = 2'b10; step();
        checks++; if (irq_o[1] !== 1'b0) begin errors++; $display("FAIL periodic_clear%0d: actual=%b required=0", e, irq_o[1]); end
      end
    end
    n = 0; while (!(m_cnt == 9 && m_pre == DIV - 1) && n < 40) begin step(); n++; end
    clr = 2'b10; step();
    checks++; if (irq_o[1] !== 1'b1 || t_out !== 8'd10) begin
      errors++; $display("FAIL periodic_set_beats_clear: actual irq=%b t=%0d required irq=1 t=10", irq_o[1], t_out);
    end
    checks++; if (armed_o[1] !== 1'b1) begin errors++; $display("FAIL periodic_still_armed: actual=%b required=1", armed_o[1]); end
  endtask

  task automatic test_pause_load();
    logic [W-1:0] frozen;
    int nticks;
    int n;
    frozen = W'(m_cnt);
    en = 1'b0; nticks = 0;
    for (int i = 0; i < 20; i++) begin step(); if (tick_o === 1'b1) nticks++; end
    checks++; if (t_out !== frozen || nticks !== 0) begin
      errors++; $display("FAIL pause_frozen: actual t=%0d ticks=%0d required t=%0d ticks=0", t_out, nticks, frozen);
    end
    en = 1'b1;
    clr = 2'b01; we = 2'b01; cv = W'((101 - m_cnt + MOD) % MOD); per = 1'b0; step();
    n = 0; while (m_pre != DIV - 1 && n < 8) begin step(); n++; end
    ld = 1'b1; ldv = 8'd100; step();
    checks++; if (t_out !== 8'd100 || tick_o !== 1'b0 || irq_o[0] !== 1'b0) begin
      errors++; $display("FAIL load_cycle: actual t=%0d tick=%b irq=%b required t=100 tick=0 irq=0", t_out, tick_o, irq_o[0]);
    end
    step(); step(); step();
    checks++; if (irq_o[0] !== 1'b0 || t_out !== 8'd100) begin
      errors++; $display("FAIL load_early: actual t=%0d irq=%b required t=100 irq=0", t_out, irq_o[0]);
    end
    step();
    checks++; if (irq_o[0] !== 1'b1 || t_out !== 8'd101 || armed_o[0] !== 1'b0) begin
      errors++; $display("FAIL load_match: actual t=%0d irq=%b armed=%b required t=101 irq=1 armed=0", t_out, irq_o[0], armed_o[0]);
    end
  endtask

  task automatic test_cancel_collision();
    int n;
    int expt;
    logic [W-1:0] hitv;
    we = 2'b01; cv = 8'd50; per = 1'b0; step();
    checks++; if (armed_o[0] !== 1'b1) begin errors++; $display("FAIL cancel_prearm: actual=%b required=1", armed_o[0]); end
    we = 2'b01; cv = 8'd0; step();
    checks++; if (armed_o[0] !== 1'b0 || irq_o[0] !== 1'b1) begin
      errors++; $display("FAIL cancel: actual armed=%b irq=%b required armed=0 irq=1", armed_o[0], irq_o[0]);
    end
    clr = 2'b01; we = 2'b01; cv = 8'd2; per = 1'b0; step();
    n = 0; while (!(m_pre == DIV - 1 && (m_cnt + 1) % MOD == m_tgt[0]) && n < 40) begin step(); n++; end
    hitv = W'((m_cnt + 1) % MOD);
    expt = (m_cnt + 3) % MOD;
    we = 2'b01; cv = 8'd3; step();
    checks++; if (irq_o[0] !== 1'b0 || armed_o[0] !== 1'b1 || t_out !== hitv) begin
      errors++; $display("FAIL collision_arm_wins: actual irq=%b armed=%b t=%0d required irq=0 armed=1 t=%0d", irq_o[0], armed_o[0], t_out, hitv);
    end
    n = 0; while (irq_o[0] !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (irq_o[0] !== 1'b1 || t_out !== W'(expt)) begin
      errors++; $display("FAIL collision_new_target: actual irq=%b t=%0d required irq=1 t=%0d", irq_o[0], t_out, expt);
    end
  endtask

`ifdef URD_TIMER_CAPTURE_EN
  task automatic test_capture();
    int n;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    ld = 1'b1; ldv = 8'd40; step();
    n = 0; while (!(m_cnt == 42 && m_pre == 0) && n < 40) begin step(); n++; end
    cap = 1'b1;
    step(); step();
    checks++; if (cap_flag_o !== 1'b0) begin errors++; $display("FAIL capture_early: actual=%b required=0", cap_flag_o); end
    step();
    checks++; if (cap_flag_o !== 1'b1 || cap_val_o !== 8'd42) begin
      errors++; $display("FAIL capture_value: actual flag=%b val=%0d required flag=1 val=42", cap_flag_o, cap_val_o);
    end
    clr = 2'b01; step();
    checks++; if (cap_flag_o !== 1'b0) begin errors++; $display("FAIL capture_clear: actual=%b required=0", cap_flag_o); end
    cap = 1'b0; step();
  endtask
`endif

  task automatic test_random();
    int bad_t, bad_tick, bad_irq, bad_arm;
    logic [1:0] exp_irq, exp_arm;
    bad_t = 0; bad_tick = 0; bad_irq = 0; bad_arm = 0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 39) == 0);
      ldv = W'($urandom);
      we  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      cv  = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 12));
      per = 1'($urandom);
      clr = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      step();
      exp_irq = {m_irq[1], m_irq[0]};
      exp_arm = {m_arm[1], m_arm[0]};
      checks++; if (t_out !== W'(m_cnt)) begin
        errors++; if (bad_t++ < 5) $display("FAIL rand_t_out @%0d: actual=%0d required=%0d", i, t_out, m_cnt);
      end
      checks++; if (tick_o !== m_tick) begin
        errors++; if (bad_tick++ < 5) $display("FAIL rand_tick @%0d: actual=%b required=%b", i, tick_o, m_tick);
      end
      checks++; if (irq_o !== exp_irq) begin
        errors++; if (bad_irq++ < 5) $display("FAIL rand_irq @%0d: actual=%b required=%b", i, irq_o, exp_irq);
      end
      checks++; if (armed_o !== exp_arm) begin
        errors++; if (bad_arm++ < 5) $display("FAIL rand_armed @%0d: actual=%b required=%b", i, armed_o, exp_arm);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_oneshot();
    test_periodic_wrap();
    test_pause_load();
    test_cancel_collision();
`ifdef URD_TIMER_CAPTURE_EN
    test_capture();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
